imuldiv_mul_req_driver: RTL

//   Initiator for the mulreq/mulresp val/rdy interface. Drives NUM_REQS signed multiply requests
//   (4 directed corners, then LFSR operands) into any multiplier (iterative or pipelined) and

---
 rtl/imuldiv_mul_req_driver.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imuldiv_mul_req_driver.sv
// Traffic source/sink for the imuldiv mulreq/mulresp handshake: issues signed multiply requests
// and checks the responses in order. Define IMULDIV_MULDRV_RAND_STALL_EN to add random response backpressure.
module imuldiv_mul_req_driver #(
   parameter int unsigned NUM_REQS     = 16,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   output logic [31:0] mulreq_msg_a_o,
   output logic [31:0] mulreq_msg_b_o,
   output logic        mulreq_val_o,
   input  logic        mulreq_rdy_i,
   input  logic [63:0] mulresp_msg_result_i,
   input  logic        mulresp_val_i,
   output logic        mulresp_rdy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] err_count_o
);

   // state | meaning
   // IDLE  | waiting for the first start
   // RUN   | issuing requests and consuming responses
   // DRAIN | all requests issued, consuming the remaining responses
   // DONE  | run complete, done/pass held until the next start
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int          PW    = (MAX_INFLIGHT > 2) ? $clog2(MAX_INFLIGHT) : 1;
   localparam logic [15:0] NUM   = 16'(NUM_REQS);
   localparam logic [PW:0] DEPTH = (PW+1)'(MAX_INFLIGHT);
   localparam logic [31:0] POLY  = 32'h8020_0003;

   logic [1:0]    state_q, state_d;
   logic [15:0]   sent_q, sent_d;
   logic [15:0]   recv_q, recv_d;
   logic [15:0]   err_q, err_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [63:0]   sb_mem [MAX_INFLIGHT];

   logic        running, sb_full, sb_empty, stall_ok;
   logic        req_val, resp_rdy, req_fire, resp_fire, mismatch;
   logic [31:0] op_a, op_b;
   logic signed [63:0] a_ext, b_ext, prod;

`ifdef IMULDIV_MULDRV_RAND_STALL_EN
   logic [7:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) stall_q <= 8'h5A;
      else       stall_q <= {stall_q[6:0], stall_q[7] ^ stall_q[5] ^ stall_q[4] ^ stall_q[3]};
   end

   assign stall_ok = (stall_q[1:0] != 2'b00);
`else
   assign stall_ok = 1'b1;
`endif

   assign running   = (state_q == RUN) || (state_q == DRAIN);
   assign sb_full   = (cnt_q == DEPTH);
   assign sb_empty  = (cnt_q == '0);
   assign req_val   = (state_q == RUN) && (sent_q < NUM) && !sb_full;
   assign resp_rdy  = running && !sb_empty && stall_ok;
   assign req_fire  = req_val && mulreq_rdy_i;
   assign resp_fire = resp_rdy && mulresp_val_i;
   assign mismatch  = (sb_mem[rd_ptr_q] != mulresp_msg_result_i);

   always_comb begin
      op_a = lfsr_q;
      op_b = {lfsr_q[15:0], lfsr_q[31:16]};
      case (sent_q)
         16'd0: begin op_a = 32'h0000_0000; op_b = 32'h0000_0000; end
         16'd1: begin op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; end
         16'd2: begin op_a = 32'h8000_0000; op_b = 32'h8000_0000; end
         16'd3: begin op_a = 32'hFFFF_FFF9; op_b = 32'h0000_0003; end
         default: ;
      endcase
   end

   // Operands are a pure function of sent/lfsr, so they hold while the request is stalled.
   assign mulreq_msg_a_o = req_val ? op_a : 32'h0;
   assign mulreq_msg_b_o = req_val ? op_b : 32'h0;
   assign mulreq_val_o   = req_val;
   assign mulresp_rdy_o  = resp_rdy;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign err_count_o    = err_q;

   assign a_ext = {{32{op_a[31]}}, op_a};
   assign b_ext = {{32{op_b[31]}}, op_b};
   assign prod  = a_ext * b_ext;

   always_comb begin
      state_d  = state_q;
      sent_d   = sent_q;
      recv_d   = recv_q;
      err_d    = err_q;
      lfsr_d   = lfsr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      pass_d   = pass_q;
      case (state_q)
         RUN, DRAIN: begin
            if (req_fire) begin
               sent_d   = sent_q + 16'd1;
               wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
               if (sent_q >= 16'd4)
                  lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
            end
            if (resp_fire) begin
               recv_d   = recv_q + 16'd1;
               rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
               if (mismatch && (err_q != 16'hFFFF))
                  err_d = err_q + 16'd1;
            end
            case ({req_fire, resp_fire})
               2'b10:   cnt_d = cnt_q + {{PW{1'b0}}, 1'b1};
               2'b01:   cnt_d = cnt_q - {{PW{1'b0}}, 1'b1};
               default: cnt_d = cnt_q;
            endcase
            if (recv_d == NUM) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == 16'd0);
            end else if (sent_d == NUM) begin
               state_d = DRAIN;
            end
         end
         default: begin
            if (start_i) begin
               state_d  = RUN;
               sent_d   = '0;
               recv_d   = '0;
               err_d    = '0;
               lfsr_d   = LFSR_SEED;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               cnt_d    = '0;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sent_q   <= '0;
         recv_q   <= '0;
         err_q    <= '0;
         lfsr_q   <= LFSR_SEED;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sent_q   <= sent_d;
         recv_q   <= recv_d;
         err_q    <= err_d;
         lfsr_q   <= lfsr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) sb_mem[wr_ptr_q] <= prod;
   end

endmodule
